pi1_arb: RTL and testbench

//  N-master to 1-slave PerInt (pi1) arbiter with round-robin fairness and registered request capture.

---
 rtl/pi1_arb_pkg.sv | 24 ++
 rtl/pi1_arb_rrsel.sv | 33 +++
 rtl/pi1_arb.sv | 191 +++++++++++++++++++
 tb/tb_pi1_arb.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pi1_arb_pkg.sv
// Shared definitions for the pi1 round-robin arbiter: op codes, FSM states, op helpers.
// The optional transfer timeout is enabled with PI1ARB_TIMEOUT_EN.
package pi1_arb_pkg;

    typedef enum logic [1:0] {
        PINOOP = 2'd0,
        PIWROP = 2'd1,
        PIRDOP = 2'd2,
        PIRWOP = 2'd3
    } pi1_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_TMO  = 2'd3
    } pi1_arb_state_e;

    // RD and RW both return data.
    function automatic logic op_is_read(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/pi1_arb_rrsel.sv
// Rotating priority encoder: first asserted request at or above i_ptr, wrapping at N.
module pi1_arb_rrsel #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic         o_valid,
    output logic [W-1:0] o_idx
);

    logic [2*N-1:0] w_rot;
    int             w_sum;

    always_comb begin
        w_rot   = {i_req, i_req} >> i_ptr;
        o_valid = 1'b0;
        o_idx   = '0;
        w_sum   = 0;
        // Scan downward so the lowest rotated position wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_valid = 1'b1;
                w_sum   = int'(i_ptr) + k;
                if (w_sum >= N) begin
                    w_sum = w_sum - N;
                end
                o_idx = W'(w_sum);
            end
        end
    end

endmodule

// File: rtl/pi1_arb.sv
// N-master to 1-slave pi1 arbiter, round-robin, request latched on grant.
// Define PI1ARB_TIMEOUT_EN to abort transfers stuck in REQ/RSP for TIMEOUTCNT cycles.
//
//  state | meaning
//  IDLE  | pick a winner, accept its request combinationally
//  REQ   | latched request presented to the slave
//  RSP   | read response phase, slave data routed to the owner
//  TMO   | timeout abort cycle (only with PI1ARB_TIMEOUT_EN)
module pi1_arb
    import pi1_arb_pkg::*;
#(
    parameter  int MASTERCOUNT = 2,
    parameter  int ARCHBITSZ   = 32,
    parameter  int TIMEOUTCNT  = 256,
    localparam int ADDRBITSZ   = ARCHBITSZ - $clog2(ARCHBITSZ / 8),
    localparam int SELBITSZ    = ARCHBITSZ / 8,
    localparam int GNTW        = (MASTERCOUNT > 1) ? $clog2(MASTERCOUNT) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [2*MASTERCOUNT-1:0]        m_op_i,
    input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i,
    input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i,
    input  logic [SELBITSZ*MASTERCOUNT-1:0]  m_sel_i,
    output logic [ARCHBITSZ-1:0]            m_data_o,
    output logic [MASTERCOUNT-1:0]          m_rdy_o,
    output logic [1:0]                      s_op_o,
    output logic [ADDRBITSZ-1:0]            s_addr_o,
    output logic [ARCHBITSZ-1:0]            s_data_o,
    output logic [SELBITSZ-1:0]             s_sel_o,
    input  logic [ARCHBITSZ-1:0]            s_data_i,
    input  logic                            s_rdy_i,
    output logic [GNTW-1:0]                 gnt_o,
`ifdef PI1ARB_TIMEOUT_EN
    output logic                            tmout_o,
`endif
    output logic                            busy_o
);

    pi1_arb_state_e       r_state;
    logic [GNTW-1:0]      r_owner;
    logic [GNTW-1:0]      r_rrptr;
    logic                 r_is_rd;
    logic [1:0]           r_s_op;
    logic [ADDRBITSZ-1:0] r_s_addr;
    logic [ARCHBITSZ-1:0] r_s_data;
    logic [SELBITSZ-1:0]  r_s_sel;
`ifdef PI1ARB_TIMEOUT_EN
    localparam int TMRW = $clog2(TIMEOUTCNT + 1);
    logic [TMRW-1:0]      r_tmr;
`endif

    logic [MASTERCOUNT-1:0] w_req;
    logic                   w_valid;
    logic [GNTW-1:0]        w_idx;
    logic [GNTW-1:0]        w_rrnext;
    logic [1:0]             w_op;
    logic [ADDRBITSZ-1:0]   w_addr;
    logic [ARCHBITSZ-1:0]   w_data;
    logic [SELBITSZ-1:0]    w_sel;

    always_comb begin
        w_req  = '0;
        w_op   = PINOOP;
        w_addr = '0;
        w_data = '0;
        w_sel  = '0;
        for (int i = 0; i < MASTERCOUNT; i++) begin
            w_req[i] = (m_op_i[2*i +: 2] != PINOOP);
            if (w_idx == GNTW'(i)) begin
                w_op   = m_op_i[2*i +: 2];
                w_addr = m_addr_i[ADDRBITSZ*i +: ADDRBITSZ];
                w_data = m_data_i[ARCHBITSZ*i +: ARCHBITSZ];
                w_sel  = m_sel_i[SELBITSZ*i +: SELBITSZ];
            end
        end
    end

    pi1_arb_rrsel #(
        .N (MASTERCOUNT),
        .W (GNTW)
    ) u_rrsel (
        .i_req   (w_req),
        .i_ptr   (r_rrptr),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    always_comb begin
        w_rrnext = (int'(r_owner) >= MASTERCOUNT - 1) ? '0 : r_owner + 1'b1;
    end

    // The IDLE accept is combinational, so it is gated by reset to keep outputs quiet.
    always_comb begin
        m_rdy_o  = '0;
        m_data_o = '0;
        for (int i = 0; i < MASTERCOUNT; i++) begin
            case (r_state)
                ST_IDLE: if (!rst_i && w_valid && (w_idx == GNTW'(i))) m_rdy_o[i] = 1'b1;
                ST_RSP:  if (r_owner == GNTW'(i)) m_rdy_o[i] = s_rdy_i;
                ST_TMO:  if (r_is_rd && (r_owner == GNTW'(i))) m_rdy_o[i] = 1'b1;
                default: ;
            endcase
        end
        if (r_state == ST_RSP) begin
            m_data_o = s_data_i;
        end else if ((r_state == ST_TMO) && r_is_rd) begin
            m_data_o = '1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_rrptr  <= '0;
            r_is_rd  <= 1'b0;
            r_s_op   <= PINOOP;
            r_s_addr <= '0;
            r_s_data <= '0;
            r_s_sel  <= '0;
`ifdef PI1ARB_TIMEOUT_EN
            r_tmr    <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_owner  <= w_idx;
                        r_is_rd  <= op_is_read(w_op);
                        r_s_op   <= w_op;
                        r_s_addr <= w_addr;
                        r_s_data <= w_data;
                        r_s_sel  <= w_sel;
                        r_state  <= ST_REQ;
`ifdef PI1ARB_TIMEOUT_EN
                        r_tmr    <= TMRW'(TIMEOUTCNT - 1);
`endif
                    end
                end
                ST_REQ: begin
                    if (s_rdy_i) begin
                        r_s_op <= PINOOP;
                        if (r_is_rd) begin
                            r_state <= ST_RSP;
                        end else begin
                            r_state <= ST_IDLE;
                            r_rrptr <= w_rrnext;
                        end
`ifdef PI1ARB_TIMEOUT_EN
                        r_tmr <= r_tmr - 1'b1;
                    end else if (r_tmr == '0) begin
                        r_s_op  <= PINOOP;
                        r_state <= ST_TMO;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
`endif
                    end
                end
                ST_RSP: begin
                    if (s_rdy_i) begin
                        r_state <= ST_IDLE;
                        r_rrptr <= w_rrnext;
`ifdef PI1ARB_TIMEOUT_EN
                    end else if (r_tmr == '0) begin
                        r_state <= ST_TMO;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
`endif
                    end
                end
                ST_TMO: begin
                    r_state <= ST_IDLE;
                    r_rrptr <= w_rrnext;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_op_o   = r_s_op;
    assign s_addr_o = r_s_addr;
    assign s_data_o = r_s_data;
    assign s_sel_o  = r_s_sel;
    assign gnt_o    = r_owner;
    assign busy_o   = (r_state != ST_IDLE);
`ifdef PI1ARB_TIMEOUT_EN
    assign tmout_o  = (r_state == ST_TMO);
`endif

endmodule

// File: tb/tb_pi1_arb.sv
// Directed bench for pi1_arb: a 4-master instance and a 1-master instance side by side.
module tb_pi1_arb;

    localparam int M  = 4;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2*M-1:0]  a_op;
    logic [AW*M-1:0] a_addr;
    logic [DW*M-1:0] a_wdata;
    logic [SW*M-1:0] a_sel;
    logic [DW-1:0]   a_mdata;
    logic [M-1:0]    a_rdy;
    logic [1:0]      a_sop;
    logic [AW-1:0]   a_saddr;
    logic [DW-1:0]   a_sdata_o;
    logic [SW-1:0]   a_ssel;
    logic [DW-1:0]   a_sdata_i;
    logic            a_srdy;
    logic [1:0]      a_gnt;
    logic            a_busy;
`ifdef PI1ARB_TIMEOUT_EN
    logic            a_tmout;
`endif

    logic [1:0]      b_op;
    logic [AW-1:0]   b_addr;
    logic [DW-1:0]   b_wdata;
    logic [SW-1:0]   b_sel;
    logic [DW-1:0]   b_mdata;
    logic [0:0]      b_rdy;
    logic [1:0]      b_sop;
    logic [AW-1:0]   b_saddr;
    logic [DW-1:0]   b_sdata_o;
    logic [SW-1:0]   b_ssel;
    logic [DW-1:0]   b_sdata_i;
    logic            b_srdy;
    logic [0:0]      b_gnt;
    logic            b_busy;
`ifdef PI1ARB_TIMEOUT_EN
    logic            b_tmout;
`endif

    pi1_arb #(.MASTERCOUNT(M), .ARCHBITSZ(DW), .TIMEOUTCNT(8)) u_dut4 (
        .clk_i    (clk),
        .rst_i    (rst),
        .m_op_i   (a_op),
        .m_addr_i (a_addr),
        .m_data_i (a_wdata),
        .m_sel_i  (a_sel),
        .m_data_o (a_mdata),
        .m_rdy_o  (a_rdy),
        .s_op_o   (a_sop),
        .s_addr_o (a_saddr),
        .s_data_o (a_sdata_o),
        .s_sel_o  (a_ssel),
        .s_data_i (a_sdata_i),
        .s_rdy_i  (a_srdy),
        .gnt_o    (a_gnt),
`ifdef PI1ARB_TIMEOUT_EN
        .tmout_o  (a_tmout),
`endif
        .busy_o   (a_busy)
    );

    pi1_arb #(.MASTERCOUNT(1), .ARCHBITSZ(DW), .TIMEOUTCNT(8)) u_dut1 (
        .clk_i    (clk),
        .rst_i    (rst),
        .m_op_i   (b_op),
        .m_addr_i (b_addr),
        .m_data_i (b_wdata),
        .m_sel_i  (b_sel),
        .m_data_o (b_mdata),
        .m_rdy_o  (b_rdy),
        .s_op_o   (b_sop),
        .s_addr_o (b_saddr),
        .s_data_o (b_sdata_o),
        .s_sel_o  (b_ssel),
        .s_data_i (b_sdata_i),
        .s_rdy_i  (b_srdy),
        .gnt_o    (b_gnt),
`ifdef PI1ARB_TIMEOUT_EN
        .tmout_o  (b_tmout),
`endif
        .busy_o   (b_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [1:0] op);
        a_op[2*i +: 2] = op;
    endtask

    // One write by master g, expected to win arbitration now; slave ready throughout.
    task automatic wr_step(input int g, input string tag);
        #1;
        chk($sformatf("%s_acc_rdy%0d", tag, g), 64'(a_rdy), 64'(1) << g);
        chk($sformatf("%s_acc_busy%0d", tag, g), 64'(a_busy), 64'd0);
        step();
        set_op(g, 2'd0);
        #1;
        chk($sformatf("%s_gnt%0d", tag, g), 64'(a_gnt), 64'(g));
        chk($sformatf("%s_sop%0d", tag, g), 64'(a_sop), 64'd1);
        chk($sformatf("%s_saddr%0d", tag, g), 64'(a_saddr), 64'h100 + 64'(g));
        chk($sformatf("%s_sdata%0d", tag, g), 64'(a_sdata_o), 64'hD000 + 64'(g));
        chk($sformatf("%s_ssel%0d", tag, g), 64'(a_ssel), 64'(g + 1));
        chk($sformatf("%s_req_rdy%0d", tag, g), 64'(a_rdy), 64'd0);
        step();
    endtask

    initial begin
        rst       = 1'b1;
        a_op      = '0;
        a_srdy    = 1'b1;
        a_sdata_i = '0;
        for (int i = 0; i < M; i++) begin
            a_addr[AW*i +: AW]  = AW'(32'h100 + i);
            a_wdata[DW*i +: DW] = DW'(32'hD000 + i);
            a_sel[SW*i +: SW]   = SW'(i + 1);
        end
        b_op      = 2'd0;
        b_addr    = AW'(32'h20);
        b_wdata   = 32'h0000_00AB;
        b_sel     = 4'hF;
        b_sdata_i = 32'h0000_0077;
        b_srdy    = 1'b1;

        // reset state, with a request pending to prove the accept is held off
        #2;
        set_op(0, 2'd2);
        #1;
        chk("rst_rdy", 64'(a_rdy), 64'd0);
        chk("rst_sop", 64'(a_sop), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_gnt", 64'(a_gnt), 64'd0);
        chk("rst_mdata", 64'(a_mdata), 64'd0);
        chk("rst_b_rdy", 64'(b_rdy), 64'd0);
        step();
        set_op(0, 2'd0);
        step();
        rst = 1'b0;
        step();

        // single read by M2: accept cycle 0, response cycle 2
        a_addr[AW*2 +: AW] = AW'(32'h10);
        a_sdata_i = 32'h0000_CAFE;
        set_op(2, 2'd2);
        #1;
        chk("t1_c0_rdy", 64'(a_rdy), 64'b0100);
        chk("t1_c0_mdata", 64'(a_mdata), 64'd0);
        step();
        set_op(2, 2'd0);
        #1;
        chk("t1_c1_sop", 64'(a_sop), 64'd2);
        chk("t1_c1_saddr", 64'(a_saddr), 64'h10);
        chk("t1_c1_rdy", 64'(a_rdy), 64'd0);
        chk("t1_c1_gnt", 64'(a_gnt), 64'd2);
        chk("t1_c1_busy", 64'(a_busy), 64'd1);
        step();
        chk("t1_c2_rdy", 64'(a_rdy), 64'b0100);
        chk("t1_c2_mdata", 64'(a_mdata), 64'hCAFE);
        chk("t1_c2_sop", 64'(a_sop), 64'd0);
        step();
        chk("t1_c3_busy", 64'(a_busy), 64'd0);
        chk("t1_c3_mdata", 64'(a_mdata), 64'd0);
        chk("t1_c3_rdy", 64'(a_rdy), 64'd0);
        a_addr[AW*2 +: AW] = AW'(32'h102);

        // rrptr is 3 now; one M3 write brings it to 0
        set_op(3, 2'd1);
        wr_step(3, "t2pre");
        for (int i = 0; i < M; i++) set_op(i, 2'd1);
        wr_step(0, "t2a");
        wr_step(1, "t2a");
        wr_step(2, "t2a");
        wr_step(3, "t2a");
        // rrptr back at 0: M0 must beat M3
        set_op(0, 2'd1);
        set_op(3, 2'd1);
        wr_step(0, "t2chk");
        wr_step(3, "t2chk");
        // M1 alone moves rrptr to 2
        set_op(1, 2'd1);
        wr_step(1, "t2mid");
        for (int i = 0; i < M; i++) set_op(i, 2'd1);
        wr_step(2, "t2b");
        wr_step(3, "t2b");
        wr_step(0, "t2b");
        wr_step(1, "t2b");

        // slave stall: 5 cycles in REQ, 3 in RSP; M0 wins with rrptr=2
        a_addr[AW*0 +: AW] = AW'(32'h55);
        a_srdy = 1'b0;
        a_sdata_i = 32'h0000_1234;
        set_op(0, 2'd2);
        #1;
        chk("t3_acc_rdy", 64'(a_rdy), 64'b0001);
        step();
        set_op(0, 2'd0);
        a_addr[AW*0 +: AW] = AW'(32'h3AA);
        #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t3_req_sop%0d", c), 64'(a_sop), 64'd2);
            chk($sformatf("t3_req_saddr%0d", c), 64'(a_saddr), 64'h55);
            chk($sformatf("t3_req_rdy%0d", c), 64'(a_rdy), 64'd0);
            step();
        end
        a_srdy = 1'b1;
        #1;
        chk("t3_req_last_sop", 64'(a_sop), 64'd2);
        step();
        a_srdy = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("t3_rsp_rdy%0d", c), 64'(a_rdy), 64'd0);
            chk($sformatf("t3_rsp_sop%0d", c), 64'(a_sop), 64'd0);
            chk($sformatf("t3_rsp_busy%0d", c), 64'(a_busy), 64'd1);
            step();
        end
        a_srdy = 1'b1;
        #1;
        chk("t3_rsp_rdy", 64'(a_rdy), 64'b0001);
        chk("t3_rsp_mdata", 64'(a_mdata), 64'h1234);
        step();
        chk("t3_end_busy", 64'(a_busy), 64'd0);
        a_addr[AW*0 +: AW] = AW'(32'h100);

        // reset during RSP of an M1 read (rrptr=1)
        a_sdata_i = 32'h0000_BEEF;
        set_op(1, 2'd2);
        #1;
        chk("t4_acc_rdy", 64'(a_rdy), 64'b0010);
        step();
        set_op(1, 2'd0);
        step();
        chk("t4_rsp_rdy", 64'(a_rdy), 64'b0010);
        rst = 1'b1;
        #1;
        chk("t4_rst_rdy", 64'(a_rdy), 64'd0);
        chk("t4_rst_mdata", 64'(a_mdata), 64'd0);
        chk("t4_rst_busy", 64'(a_busy), 64'd0);
        chk("t4_rst_sop", 64'(a_sop), 64'd0);
        chk("t4_rst_gnt", 64'(a_gnt), 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("t4_post_busy", 64'(a_busy), 64'd0);
        chk("t4_post_rdy", 64'(a_rdy), 64'd0);
        chk("t4_post_mdata", 64'(a_mdata), 64'd0);
        set_op(0, 2'd1);
        set_op(3, 2'd1);
        wr_step(0, "t4ptr");
        wr_step(3, "t4ptr");

`ifdef PI1ARB_TIMEOUT_EN
        // timeout on a stuck M2 read; M3 is waiting behind it
        a_srdy = 1'b0;
        set_op(2, 2'd2);
        set_op(3, 2'd1);
        #1;
        chk("t5_acc_rdy", 64'(a_rdy), 64'b0100);
        step();
        set_op(2, 2'd0);
        #1;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("t5_wait_sop%0d", c), 64'(a_sop), 64'd2);
            chk($sformatf("t5_wait_tmo%0d", c), 64'(a_tmout), 64'd0);
            step();
        end
        chk("t5_tmo", 64'(a_tmout), 64'd1);
        chk("t5_tmo_rdy", 64'(a_rdy), 64'b0100);
        chk("t5_tmo_mdata", 64'(a_mdata), 64'hFFFF_FFFF);
        chk("t5_tmo_sop", 64'(a_sop), 64'd0);
        step();
        chk("t5_after_tmo", 64'(a_tmout), 64'd0);
        a_srdy = 1'b1;
        wr_step(3, "t5nxt");
`endif

        // single master back-to-back WR, RD, WR
        b_op = 2'd1;
        #1;
        chk("t6_c0_rdy", 64'(b_rdy), 64'd1);
        chk("t6_c0_busy", 64'(b_busy), 64'd0);
        step();
        b_op = 2'd2;
        #1;
        chk("t6_c1_busy", 64'(b_busy), 64'd1);
        chk("t6_c1_sop", 64'(b_sop), 64'd1);
        chk("t6_c1_sdata", 64'(b_sdata_o), 64'hAB);
        chk("t6_c1_rdy", 64'(b_rdy), 64'd0);
        step();
        chk("t6_c2_busy", 64'(b_busy), 64'd0);
        chk("t6_c2_rdy", 64'(b_rdy), 64'd1);
        step();
        b_op = 2'd1;
        #1;
        chk("t6_c3_sop", 64'(b_sop), 64'd2);
        chk("t6_c3_busy", 64'(b_busy), 64'd1);
        step();
        chk("t6_c4_rdy", 64'(b_rdy), 64'd1);
        chk("t6_c4_mdata", 64'(b_mdata), 64'h77);
        chk("t6_c4_busy", 64'(b_busy), 64'd1);
        step();
        chk("t6_c5_busy", 64'(b_busy), 64'd0);
        chk("t6_c5_rdy", 64'(b_rdy), 64'd1);
        step();
        b_op = 2'd0;
        #1;
        chk("t6_c6_sop", 64'(b_sop), 64'd1);
        chk("t6_c6_busy", 64'(b_busy), 64'd1);
        step();
        chk("t6_c7_busy", 64'(b_busy), 64'd0);
        chk("t6_c7_gnt", 64'(b_gnt), 64'd0);
        chk("t6_c7_rdy", 64'(b_rdy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
